// File: rtl/subreg_rd_resp.sv
// Read responder for a software register bank: internal regs served from reg_q_i, external regs via strobe/ack with timeout.
// Latency: internal/illegal response valid 1 cycle after accept; external response valid 1 cycle after ack (or timeout).
// Backpressure: one transaction in flight; req_ready low until the response handshakes, response held while rsp_ready_i=0.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req_valid_i/req_ready_o      read request handshake, req_addr_i = register index
//   rsp_valid_o/rsp_ready_i      response handshake, rsp_data_o/rsp_err_o = payload
//   reg_q_i                      flattened register values, reg i at [i*DW +: DW]
//   rc_clr_o                     one-cycle clear for read-to-clear regs (accept cycle)
//   ext_re_o                     one-cycle read strobe for external regs (accept cycle)
//   ext_rdata_i, ext_ack_i       external read completion
module subreg_rd_resp #(
    parameter int                 NumRegs       = 8,
    parameter int                 DW            = 32,
    parameter int                 AW            = 3,
    parameter logic [NumRegs-1:0] ExtMask       = '0,
    parameter logic [NumRegs-1:0] RcMask        = '0,
    parameter int                 TimeoutCycles = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [AW-1:0]         req_addr_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DW-1:0]         rsp_data_o,
    output logic                  rsp_err_o,
    input  logic [NumRegs*DW-1:0] reg_q_i,
    output logic [NumRegs-1:0]    rc_clr_o,
    output logic [NumRegs-1:0]    ext_re_o,
    input  logic [DW-1:0]         ext_rdata_i,
    input  logic                  ext_ack_i
);

    localparam int            CW       = $clog2(TimeoutCycles);
    localparam logic [CW-1:0] CNT_LAST = CW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXT_WAIT,
        RESP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [DW-1:0] data_q, data_n;
    logic          err_q, err_n;

    logic          accept;
    logic          hit;
    logic          hit_ext;
    logic [DW-1:0] sel_q;
    logic [NumRegs-1:0] rc_vec;
    logic [NumRegs-1:0] ext_vec;

    // Gating with rst_i keeps the strobes and ready quiet while reset is held,
    // even though the state register already sits in IDLE.
    assign accept = (state == IDLE) && req_valid_i && !rst_i;

    // Address decode: any address not matching a register index is illegal.
    // External registers never get an RC clear, whatever RcMask says.
    always_comb begin
        hit     = 1'b0;
        hit_ext = 1'b0;
        sel_q   = '0;
        rc_vec  = '0;
        ext_vec = '0;
        for (int i = 0; i < NumRegs; i++) begin
            if (req_addr_i == AW'(i)) begin
                hit        = 1'b1;
                hit_ext    = ExtMask[i];
                sel_q      = reg_q_i[i*DW +: DW];
                ext_vec[i] = accept && ExtMask[i];
                rc_vec[i]  = accept && RcMask[i] && !ExtMask[i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            data_q <= data_n;
            err_q  <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        data_n  = data_q;
        err_n   = err_q;
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    if (!hit) begin
                        state_n = RESP;
                        data_n  = '0;
                        err_n   = 1'b1;
                    end else if (hit_ext) begin
                        state_n = EXT_WAIT;
                        cnt_n   = '0;
                    end else begin
                        // Pre-clear value: the RC clear lands in the register a cycle later.
                        state_n = RESP;
                        data_n  = sel_q;
                        err_n   = 1'b0;
                    end
                end
            end
            EXT_WAIT: begin
                // Ack is tested first so an ack on the last allowed cycle still succeeds.
                if (ext_ack_i) begin
                    state_n = RESP;
                    data_n  = ext_rdata_i;
                    err_n   = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    state_n = RESP;
                    data_n  = '0;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign req_ready_o = (state == IDLE) && !rst_i;
    assign rsp_valid_o = (state == RESP);
    assign rsp_data_o  = data_q;
    assign rsp_err_o   = err_q;
    assign rc_clr_o    = rc_vec;
    assign ext_re_o    = ext_vec;

endmodule

// File: tb/tb_subreg_rd_resp.sv
module tb_subreg_rd_resp;

    localparam int N  = 6;
    localparam int DW = 32;
    localparam int AW = 3;

    logic            clk;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   req_addr;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic [N*DW-1:0] reg_q;
    logic [N-1:0]    rc_clr;
    logic [N-1:0]    ext_re;
    logic [DW-1:0]   ext_rdata;
    logic            ext_ack;

    int checks = 0;
    int passed = 0;

    subreg_rd_resp #(
        .NumRegs      (N),
        .DW           (DW),
        .AW           (AW),
        .ExtMask      (6'b000010),
        .RcMask       (6'b001010),
        .TimeoutCycles(16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_addr_i (req_addr),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_data_o (rsp_data),
        .rsp_err_o  (rsp_err),
        .reg_q_i    (reg_q),
        .rc_clr_o   (rc_clr),
        .ext_re_o   (ext_re),
        .ext_rdata_i(ext_rdata),
        .ext_ack_i  (ext_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          err;
        logic [N-1:0]  rc;
    } vec_t;

    vec_t vecs[6];

    // Issue an accept on the external register and leave the FSM in EXT_WAIT cycle 1.
    task automatic start_ext(input string tag);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 3'd1;
        #1;
        check({tag, "_ext_re"}, 32'(ext_re), 32'h02);
        check({tag, "_rc_clr"}, 32'(rc_clr), 32'h00);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, "_wait_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_wait_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_wait_ext_re"}, 32'(ext_re), 32'h00);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b1;
        ext_rdata = '0;
        ext_ack   = 1'b0;
        reg_q     = {32'h0BAD_F00D, 32'hCAFE_0004, 32'h0000_00F0,
                     32'hA5A5_0001, 32'h1234_5678, 32'h1111_0000};

        vecs[0] = '{addr: 3'd2, data: 32'hA5A5_0001, err: 1'b0, rc: 6'h00};
        vecs[1] = '{addr: 3'd3, data: 32'h0000_00F0, err: 1'b0, rc: 6'h08};
        vecs[2] = '{addr: 3'd7, data: 32'h0000_0000, err: 1'b1, rc: 6'h00};
        vecs[3] = '{addr: 3'd6, data: 32'h0000_0000, err: 1'b1, rc: 6'h00};
        vecs[4] = '{addr: 3'd0, data: 32'h1111_0000, err: 1'b0, rc: 6'h00};
        vecs[5] = '{addr: 3'd5, data: 32'h0BAD_F00D, err: 1'b0, rc: 6'h00};

        // Reset state
        #12;
        check("rst_valid", 32'(rsp_valid), 32'h0);
        check("rst_data", rsp_data, 32'h0);
        check("rst_err", 32'(rsp_err), 32'h0);
        check("rst_rc_clr", 32'(rc_clr), 32'h0);
        check("rst_ext_re", 32'(ext_re), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'h1);

        // Internal and illegal reads with rsp_ready held high
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_addr  = vecs[i].addr;
            #1;
            check("vec_accept_rc_clr", 32'(rc_clr), 32'(vecs[i].rc));
            check("vec_accept_ext_re", 32'(ext_re), 32'h0);
            check("vec_accept_ready", 32'(req_ready), 32'h1);
            @(posedge clk); #1;
            req_valid = 1'b0;
            check("vec_rsp_valid", 32'(rsp_valid), 32'h1);
            check("vec_rsp_data", rsp_data, vecs[i].data);
            check("vec_rsp_err", 32'(rsp_err), 32'(vecs[i].err));
            check("vec_rsp_rc_clr", 32'(rc_clr), 32'h0);
            @(posedge clk); #1;
            check("vec_done_valid", 32'(rsp_valid), 32'h0);
        end

        // External read, ack in the third EXT_WAIT cycle
        start_ext("ext3");
        repeat (2) @(posedge clk);
        #1;
        ext_ack   = 1'b1;
        ext_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        ext_ack = 1'b0;
        check("ext3_valid", 32'(rsp_valid), 32'h1);
        check("ext3_data", rsp_data, 32'hDEAD_BEEF);
        check("ext3_err", 32'(rsp_err), 32'h0);
        @(posedge clk); #1;
        check("ext3_done", 32'(rsp_valid), 32'h0);

        // External timeout: no ack across all 16 EXT_WAIT cycles
        start_ext("tmo");
        repeat (15) @(posedge clk);
        #1;
        check("tmo_cycle16_valid", 32'(rsp_valid), 32'h0);
        @(posedge clk); #1;
        check("tmo_valid", 32'(rsp_valid), 32'h1);
        check("tmo_data", rsp_data, 32'h0);
        check("tmo_err", 32'(rsp_err), 32'h1);
        @(posedge clk); #1;

        // Ack on the 16th EXT_WAIT cycle beats the timeout
        start_ext("ack16");
        repeat (15) @(posedge clk);
        #1;
        check("ack16_pre_valid", 32'(rsp_valid), 32'h0);
        ext_ack   = 1'b1;
        ext_rdata = 32'h600D_0016;
        @(posedge clk); #1;
        ext_ack = 1'b0;
        check("ack16_valid", 32'(rsp_valid), 32'h1);
        check("ack16_data", rsp_data, 32'h600D_0016);
        check("ack16_err", 32'(rsp_err), 32'h0);
        @(posedge clk); #1;

        // Backpressure: response held 5 cycles while another (RC) request is offered
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 3'd4;
        @(posedge clk); #1;
        req_addr = 3'd3;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(rsp_valid), 32'h1);
            check("bp_data", rsp_data, 32'hCAFE_0004);
            check("bp_err", 32'(rsp_err), 32'h0);
            check("bp_req_ready", 32'(req_ready), 32'h0);
            check("bp_rc_clr", 32'(rc_clr), 32'h0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(rsp_valid), 32'h0);
        check("bp_release_data", rsp_data, 32'hCAFE_0004);
        @(posedge clk); #1;
        check("bp_no_stray_rsp", 32'(rsp_valid), 32'h0);

        // Reset while in EXT_WAIT, then a late ack must be ignored
        start_ext("rstw");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstw_valid", 32'(rsp_valid), 32'h0);
        check("rstw_ready", 32'(req_ready), 32'h0);
        check("rstw_data", rsp_data, 32'h0);
        check("rstw_err", 32'(rsp_err), 32'h0);
        check("rstw_ext_re", 32'(ext_re), 32'h0);
        ext_ack   = 1'b1;
        ext_rdata = 32'hBAAD_BAAD;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("late_ack_valid", 32'(rsp_valid), 32'h0);
        check("late_ack_ready", 32'(req_ready), 32'h1);
        check("late_ack_data", rsp_data, 32'h0);
        @(posedge clk); #1;
        check("late_ack_valid2", 32'(rsp_valid), 32'h0);
        ext_ack = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
